// File: rtl/coin_pkg.sv
// coin_pkg: shared types and constants for the coin front-end.
// Change-FSM state, credit width and the half-yuan unit.
package coin_pkg;

  localparam int CNT_W = 4;

  localparam logic [CNT_W-1:0] HALF_UNIT = 4'd1;
  localparam logic [CNT_W-1:0] CNT_MAX   = 4'd15;

  typedef enum logic [1:0] {
    IDLE,
    PAY,
    GAP
  } chg_state_t;

endpackage

// File: rtl/coin_debounce.sv
// coin_debounce: 2-FF synchroniser, stability counter, one-shot.
// Pulse on an accepted press; re-arm after a stable release.
module coin_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic RST,
  input  logic btn,
  output logic pulse
);

  localparam int CW = $clog2(DEB_CYCLES);

  logic          s_meta;
  logic          s_sync;
  logic          pressed;
  logic [CW-1:0] run;

  // run counts consecutive samples disagreeing with the accepted state
  always_ff @(posedge clk) begin
    if (RST) begin
      s_meta  <= 1'b1;
      s_sync  <= 1'b1;
      pressed <= 1'b0;
      run     <= '0;
      pulse   <= 1'b0;
    end else begin
      s_meta <= btn;
      s_sync <= s_meta;
      pulse  <= 1'b0;
      if ((~s_sync) != pressed) begin
        if (run == CW'(DEB_CYCLES - 1)) begin
          run     <= '0;
          pressed <= ~s_sync;
          pulse   <= ~s_sync;
        end else begin
          run <= run + 1'b1;
        end
      end else begin
        run <= '0;
      end
    end
  end

endmodule

// File: rtl/coin_accumulator.sv
// coin_accumulator: debounced coins, credit counter, price compare.
// Change payout is compiled in only when COIN_CHANGE_EN is defined.
module coin_accumulator
  import coin_pkg::*;
#(
  parameter int PRICE      = 5,
  parameter int DEB_CYCLES = 16,
  parameter int CHANGE_GAP = 8
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             half_yuan,
  input  logic             one_yuan,
  input  logic             cnt_en,
  input  logic             cnt_clr,
  output logic             coin_half_p,
  output logic             coin_one_p,
  output logic [CNT_W-1:0] cnt,
  output logic             Eql_grt,
  output logic             change_pulse,
  output logic             change_busy
);

  localparam logic [CNT_W-1:0] PRICE_V = CNT_W'(PRICE);

  logic half_acc;
  logic one_acc;
  logic one_pend;

  coin_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_half (
    .clk  (clk),
    .RST  (RST),
    .btn  (half_yuan),
    .pulse(half_acc)
  );

  coin_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_one (
    .clk  (clk),
    .RST  (RST),
    .btn  (one_yuan),
    .pulse(one_acc)
  );

  // half-yuan wins a tie; the 1 RMB coin slips one cycle
  always_ff @(posedge clk) begin
    if (RST) one_pend <= 1'b0;
    else     one_pend <= one_acc & half_acc;
  end

  assign coin_half_p = half_acc;
  assign coin_one_p  = one_pend | (one_acc & ~half_acc);

  // credit: clear beats increment, increment saturates
  always_ff @(posedge clk) begin
    if (RST) begin
      cnt <= '0;
    end else if (!cnt_clr) begin
      cnt <= '0;
    end else if (cnt_en && (cnt != CNT_MAX)) begin
      cnt <= cnt + HALF_UNIT;
    end
  end

  assign Eql_grt = (cnt >= PRICE_V);

`ifdef COIN_CHANGE_EN

  localparam int GAP_W = $clog2(CHANGE_GAP + 1);

  chg_state_t       state;
  logic             clr_q;
  logic             trig;
  logic [CNT_W-1:0] amt;
  logic [GAP_W-1:0] gap_cnt;

  assign trig = clr_q & ~cnt_clr & (cnt > PRICE_V);

  // payout FSM; trig uses the pre-clear credit
  always_ff @(posedge clk) begin
    if (RST) begin
      state        <= IDLE;
      clr_q        <= 1'b0;
      amt          <= '0;
      gap_cnt      <= '0;
      change_pulse <= 1'b0;
      change_busy  <= 1'b0;
    end else begin
      clr_q        <= cnt_clr;
      change_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (trig) begin
            amt          <= cnt - PRICE_V;
            state        <= PAY;
            change_pulse <= 1'b1;
            change_busy  <= 1'b1;
          end
        end
        PAY: begin
          amt     <= amt - HALF_UNIT;
          gap_cnt <= '0;
          if (amt == HALF_UNIT) begin
            state       <= IDLE;
            change_busy <= 1'b0;
          end else begin
            state <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_W'(CHANGE_GAP - 1)) begin
            state        <= PAY;
            change_pulse <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`else

  assign change_pulse = 1'b0;
  assign change_busy  = 1'b0;

`endif

endmodule

// File: tb/tb_coin_accumulator.sv
// tb_coin_accumulator: randomized self-checking bench.
// Reference model works from coin/credit rules, not RTL state.
module tb_coin_accumulator;

  localparam int PRICE = 5;
  localparam int DEB   = 4;
  localparam int GAP   = 2;

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic       half_yuan = 1'b1;
  logic       one_yuan = 1'b1;
  logic       cnt_en = 1'b0;
  logic       cnt_clr = 1'b1;
  logic       coin_half_p;
  logic       coin_one_p;
  logic [3:0] cnt;
  logic       Eql_grt;
  logic       change_pulse;
  logic       change_busy;

  coin_accumulator #(
    .PRICE     (PRICE),
    .DEB_CYCLES(DEB),
    .CHANGE_GAP(GAP)
  ) dut (
    .clk         (clk),
    .RST         (RST),
    .half_yuan   (half_yuan),
    .one_yuan    (one_yuan),
    .cnt_en      (cnt_en),
    .cnt_clr     (cnt_clr),
    .coin_half_p (coin_half_p),
    .coin_one_p  (coin_one_p),
    .cnt         (cnt),
    .Eql_grt     (Eql_grt),
    .change_pulse(change_pulse),
    .change_busy (change_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int half_q[$];
  int one_q[$];
  int chg_q[$];
  int busy_hits = 0;

  always @(posedge clk) begin
    #1;
    if (coin_half_p === 1'b1) half_q.push_back(cyc);
    if (coin_one_p === 1'b1) one_q.push_back(cyc);
    if (change_pulse === 1'b1) chg_q.push_back(cyc);
    if (change_busy === 1'b1) busy_hits++;
  end

  int errors = 0;
  int checks = 0;
  int m_cnt = 0;

  task automatic do_reset();
    @(negedge clk);
    RST = 1'b1;
    half_yuan = 1'b1;
    one_yuan = 1'b1;
    cnt_en = 1'b0;
    cnt_clr = 1'b1;
    m_cnt = 0;
    repeat (2) @(negedge clk);
    RST = 1'b0;
  endtask

  task automatic cnt_step(input logic en, input logic clr);
    cnt_en = en;
    cnt_clr = clr;
    if (!clr) m_cnt = 0;
    else if (en && m_cnt < 15) m_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    RST = 1'b1;
    cnt_en = 1'b1;
    half_yuan = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_cnt got=%0d exp=0", cnt);
    end
    checks++;
    if (Eql_grt !== 1'b0) begin
      errors++;
      $display("FAIL reset_eql got=%b exp=0", Eql_grt);
    end
    checks++;
    if ({coin_half_p, coin_one_p} !== 2'b00) begin
      errors++;
      $display("FAIL reset_coin got=%b%b exp=00",
               coin_half_p, coin_one_p);
    end
    checks++;
    if ({change_pulse, change_busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_chg got=%b%b exp=00",
               change_pulse, change_busy);
    end
    half_yuan = 1'b1;
    cnt_en = 1'b0;
    repeat (DEB + 3) @(negedge clk);
    RST = 1'b0;
    m_cnt = 0;
  endtask

  task automatic test_clean_press();
    int s;
    half_q.delete();
    @(negedge clk);
    s = cyc + 1;
    half_yuan = 1'b0;
    repeat (20) @(negedge clk);
    half_yuan = 1'b1;
    repeat (DEB - 2) @(negedge clk);
    half_yuan = 1'b0;
    repeat (10) @(negedge clk);
    half_yuan = 1'b1;
    repeat (DEB + 6) @(negedge clk);
    checks++;
    if (half_q.size() != 1) begin
      errors++;
      $display("FAIL press_count got=%0d exp=1", half_q.size());
    end else begin
      checks++;
      if (half_q[0] != s + DEB + 1) begin
        errors++;
        $display("FAIL press_latency got=%0d exp=%0d",
                 half_q[0] - s + 1, DEB + 2);
      end
    end
  endtask

  task automatic test_glitch_and_tie();
    int s;
    half_q.delete();
    one_q.delete();
    @(negedge clk);
    one_yuan = 1'b0;
    repeat (DEB - 1) @(negedge clk);
    one_yuan = 1'b1;
    repeat (DEB + 6) @(negedge clk);
    checks++;
    if (one_q.size() != 0) begin
      errors++;
      $display("FAIL glitch got=%0d pulses exp=0", one_q.size());
    end
    s = cyc + 1;
    half_yuan = 1'b0;
    one_yuan = 1'b0;
    repeat (8) @(negedge clk);
    half_yuan = 1'b1;
    one_yuan = 1'b1;
    repeat (DEB + 6) @(negedge clk);
    checks++;
    if (half_q.size() != 1 || one_q.size() != 1) begin
      errors++;
      $display("FAIL tie_count got=%0d/%0d exp=1/1",
               half_q.size(), one_q.size());
    end else begin
      checks++;
      if (half_q[0] != s + DEB + 1 || one_q[0] != s + DEB + 2) begin
        errors++;
        $display("FAIL tie_order got=%0d/%0d exp=%0d/%0d",
                 half_q[0], one_q[0], s + DEB + 1, s + DEB + 2);
      end
    end
  endtask

  task automatic test_debounce_random();
    int exp_h[$];
    int exp_o[$];
    int b, l, g, s;
    half_q.delete();
    one_q.delete();
    for (int i = 0; i < 14; i++) begin
      b = $urandom_range(0, 1);
      l = $urandom_range(1, 2 * DEB + 3);
      g = $urandom_range(DEB, DEB + 5);
      @(negedge clk);
      s = cyc + 1;
      if (b == 0) half_yuan = 1'b0;
      else one_yuan = 1'b0;
      if (l >= DEB) begin
        if (b == 0) exp_h.push_back(s + DEB + 1);
        else exp_o.push_back(s + DEB + 1);
      end
      repeat (l - 1) @(negedge clk);
      @(negedge clk);
      half_yuan = 1'b1;
      one_yuan = 1'b1;
      repeat (g - 1) @(negedge clk);
    end
    repeat (DEB + 6) @(negedge clk);
    checks++;
    if (half_q.size() != exp_h.size()) begin
      errors++;
      $display("FAIL rnd_half_count got=%0d exp=%0d",
               half_q.size(), exp_h.size());
    end else begin
      foreach (exp_h[i]) begin
        checks++;
        if (half_q[i] != exp_h[i]) begin
          errors++;
          $display("FAIL rnd_half_cyc got=%0d exp=%0d",
                   half_q[i], exp_h[i]);
        end
      end
    end
    checks++;
    if (one_q.size() != exp_o.size()) begin
      errors++;
      $display("FAIL rnd_one_count got=%0d exp=%0d",
               one_q.size(), exp_o.size());
    end else begin
      foreach (exp_o[i]) begin
        checks++;
        if (one_q[i] != exp_o[i]) begin
          errors++;
          $display("FAIL rnd_one_cyc got=%0d exp=%0d",
                   one_q[i], exp_o[i]);
        end
      end
    end
  endtask

  task automatic test_accumulate();
    do_reset();
    repeat (PRICE - 1) cnt_step(1'b1, 1'b1);
    checks++;
    if (cnt !== 4'(m_cnt) || Eql_grt !== (m_cnt >= PRICE)) begin
      errors++;
      $display("FAIL acc_below got=%0d/%b exp=%0d/%b",
               cnt, Eql_grt, m_cnt, m_cnt >= PRICE);
    end
    cnt_step(1'b1, 1'b1);
    checks++;
    if (cnt !== 4'(m_cnt) || Eql_grt !== (m_cnt >= PRICE)) begin
      errors++;
      $display("FAIL acc_price got=%0d/%b exp=%0d/%b",
               cnt, Eql_grt, m_cnt, m_cnt >= PRICE);
    end
    cnt_step(1'b0, 1'b1);
    checks++;
    if (cnt !== 4'(m_cnt)) begin
      errors++;
      $display("FAIL acc_hold got=%0d exp=%0d", cnt, m_cnt);
    end
  endtask

  task automatic test_saturate_clear();
    repeat (20) cnt_step(1'b1, 1'b1);
    checks++;
    if (cnt !== 4'(m_cnt)) begin
      errors++;
      $display("FAIL saturate got=%0d exp=%0d", cnt, m_cnt);
    end
    cnt_step(1'b1, 1'b0);
    checks++;
    if (cnt !== 4'(m_cnt) || Eql_grt !== 1'b0) begin
      errors++;
      $display("FAIL clr_prio got=%0d/%b exp=%0d/0",
               cnt, Eql_grt, m_cnt);
    end
  endtask

  task automatic test_counter_random();
    logic en, clr;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      en = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 7) != 0);
      cnt_step(en, clr);
      checks++;
      if (cnt !== 4'(m_cnt) || Eql_grt !== (m_cnt >= PRICE)) begin
        errors++;
        $display("FAIL cnt_rnd step=%0d got=%0d/%b exp=%0d/%b",
                 i, cnt, Eql_grt, m_cnt, m_cnt >= PRICE);
      end
    end
  endtask

  task automatic test_change();
    int a, n, t, exp_n, exp_busy;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      a = (k == 0) ? 8 : $urandom_range(PRICE + 1, 15);
      repeat (a) cnt_step(1'b1, 1'b1);
      chg_q.delete();
      busy_hits = 0;
      t = cyc + 1;
      cnt_step(1'b0, 1'b0);
      checks++;
      if (cnt !== 4'(m_cnt)) begin
        errors++;
        $display("FAIL chg_clr got=%0d exp=0", cnt);
      end
      n = a - PRICE;
      repeat (n * (GAP + 1) + 6) @(negedge clk);
`ifdef COIN_CHANGE_EN
      exp_n = n;
      exp_busy = (n - 1) * (GAP + 1) + 1;
`else
      exp_n = 0;
      exp_busy = 0;
`endif
      checks++;
      if (chg_q.size() != exp_n) begin
        errors++;
        $display("FAIL chg_count a=%0d got=%0d exp=%0d",
                 a, chg_q.size(), exp_n);
      end else begin
        foreach (chg_q[i]) begin
          checks++;
          if (chg_q[i] != t + i * (GAP + 1)) begin
            errors++;
            $display("FAIL chg_cyc i=%0d got=%0d exp=%0d",
                     i, chg_q[i] - t, i * (GAP + 1));
          end
        end
      end
      checks++;
      if (busy_hits != exp_busy || change_busy !== 1'b0) begin
        errors++;
        $display("FAIL chg_busy got=%0d/%b exp=%0d/0",
                 busy_hits, change_busy, exp_busy);
      end
    end
  endtask

  task automatic test_reset_mid_payout();
    int t, exp_n;
    do_reset();
    repeat (12) cnt_step(1'b1, 1'b1);
    chg_q.delete();
    t = cyc + 1;
    cnt_step(1'b0, 1'b0);
    @(negedge clk);
    RST = 1'b1;
    m_cnt = 0;
    @(negedge clk);
    checks++;
    if ({coin_half_p, coin_one_p, Eql_grt,
         change_pulse, change_busy} !== 5'b0 || cnt !== 4'd0) begin
      errors++;
      $display("FAIL midrst_outs got=%b%b%b%b%b/%0d exp=00000/0",
               coin_half_p, coin_one_p, Eql_grt,
               change_pulse, change_busy, cnt);
    end
    RST = 1'b0;
    repeat (30) @(negedge clk);
`ifdef COIN_CHANGE_EN
    exp_n = 1;
`else
    exp_n = 0;
`endif
    checks++;
    if (chg_q.size() != exp_n) begin
      errors++;
      $display("FAIL midrst_pulses got=%0d exp=%0d",
               chg_q.size(), exp_n);
    end else if (exp_n == 1) begin
      checks++;
      if (chg_q[0] != t) begin
        errors++;
        $display("FAIL midrst_first got=%0d exp=%0d", chg_q[0], t);
      end
    end
    checks++;
    if (change_busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_busy got=%b exp=0", change_busy);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch_and_tie();
    test_debounce_random();
    test_accumulate();
    test_saturate_clear();
    test_counter_random();
    test_change();
    test_reset_mid_payout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
